// File: rtl/c3_priority_heap.sv
// rtl/c3_priority_heap.sv - binary heap priority queue with one-level-per-cycle sift FSM
module c3_priority_heap #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int MAX_HEAP = 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              err,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Index math runs one bit wider than count so 2*idx+2 never wraps.
  localparam int XW = CW + 1;

  localparam logic [1:0] OP_CLEAR   = 2'b00;
  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       count_q, count_d;
  logic                res_valid_q;
  logic                err_q;
  logic [DATA_W-1:0]   res_data_q;
  logic [DATA_W-1:0]   heap_q [DEPTH];

  logic                accept, push_ok, pop_ok, rep_ok, clr_ok, illegal;
  logic                up_swap, dn_swap;
  logic [XW-1:0]       cnt_x, parent, lc, rc, win, win_lc;
  logic [CW-1:0]       last;
  logic [DATA_W-1:0]   cur_v, par_v, lc_v, rc_v, win_v;

  function automatic logic wins(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (MAX_HEAP != 0) ? (a > b) : (a < b);
  endfunction

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign res_valid = res_valid_q;
  assign err       = err_q;
  assign res_data  = res_data_q;

  assign accept  = cmd_valid && cmd_ready;
  assign push_ok = accept && (cmd_op == OP_PUSH) && !full;
  assign pop_ok  = accept && (cmd_op == OP_POP) && !empty;
  assign rep_ok  = accept && (cmd_op == OP_REPLACE) && !empty;
  assign clr_ok  = accept && (cmd_op == OP_CLEAR);
  assign illegal = accept && (((cmd_op == OP_PUSH) && full) || (cmd_op[1] && empty));

  assign cnt_x  = {1'b0, count_q};
  assign last   = count_q - CW'(1);
  assign parent = (idx_q - XW'(1)) >> 1;
  assign lc     = {idx_q[XW-2:0], 1'b1};
  assign rc     = lc + XW'(1);
  assign cur_v  = heap_q[idx_q[AW-1:0]];
  assign par_v  = heap_q[parent[AW-1:0]];
  assign lc_v   = heap_q[lc[AW-1:0]];
  assign rc_v   = heap_q[rc[AW-1:0]];

  // Left child takes ties against the right one; the parent keeps ties against both.
  always_comb begin
    win   = idx_q;
    win_v = cur_v;
    if ((lc < cnt_x) && wins(lc_v, win_v)) begin
      win   = lc;
      win_v = lc_v;
    end
    if ((rc < cnt_x) && wins(rc_v, win_v)) begin
      win   = rc;
      win_v = rc_v;
    end
  end

  assign win_lc  = {win[XW-2:0], 1'b1};
  assign up_swap = (state_q == SIFT_UP) && (idx_q != '0) && wins(cur_v, par_v);
  assign dn_swap = (state_q == SIFT_DOWN) && (win != idx_q);

  // Leaving a sift as soon as the moved key reaches the root or a leaf saves the
  // final no-swap compare cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (push_ok) begin
          count_d = count_q + CW'(1);
          idx_d   = cnt_x;
          state_d = (count_q == '0) ? IDLE : SIFT_UP;
        end else if (pop_ok) begin
          count_d = last;
          idx_d   = '0;
          state_d = (count_q >= CW'(3)) ? SIFT_DOWN : IDLE;
        end else if (rep_ok) begin
          idx_d   = '0;
          state_d = (count_q >= CW'(2)) ? SIFT_DOWN : IDLE;
        end else if (clr_ok) begin
          count_d = '0;
        end
      end
      SIFT_UP: begin
        if (up_swap) begin
          idx_d   = parent;
          state_d = (parent == '0) ? IDLE : SIFT_UP;
        end else begin
          state_d = IDLE;
        end
      end
      SIFT_DOWN: begin
        if (dn_swap) begin
          idx_d   = win;
          state_d = (win_lc < cnt_x) ? SIFT_DOWN : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      res_valid_q <= pop_ok || rep_ok;
      err_q       <= illegal;
      if (pop_ok || rep_ok) begin
        res_data_q <= heap_q[0];
      end
    end
  end

  // Array contents are don't-care after reset or CLEAR, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      heap_q[count_q[AW-1:0]] <= cmd_data;
    end else if (pop_ok) begin
      heap_q[0] <= heap_q[last[AW-1:0]];
    end else if (rep_ok) begin
      heap_q[0] <= cmd_data;
    end else if (up_swap) begin
      heap_q[idx_q[AW-1:0]]  <= par_v;
      heap_q[parent[AW-1:0]] <= cur_v;
    end else if (dn_swap) begin
      heap_q[idx_q[AW-1:0]] <= win_v;
      heap_q[win[AW-1:0]]   <= cur_v;
    end
  end

endmodule

// File: tb/tb_c3_priority_heap.sv
// tb/tb_c3_priority_heap.sv - directed vector bench for c3_priority_heap
module tb_c3_priority_heap;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [1:0] CLR = 2'b00;
  localparam logic [1:0] PSH = 2'b01;
  localparam logic [1:0] POP = 2'b10;
  localparam logic [1:0] REP = 2'b11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, res_valid, err, empty, full, busy;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data, res_data;
  logic [CW-1:0] count;

  logic          m_valid, m_ready, m_rv, m_err, m_empty, m_full, m_busy;
  logic [1:0]    m_op;
  logic [DW-1:0] m_data, m_rd;
  logic [CW-1:0] m_count;

  c3_priority_heap #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_HEAP(1)) u_max (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .res_valid(res_valid), .res_data(res_data),
    .err(err), .count(count), .empty(empty), .full(full), .busy(busy)
  );

  c3_priority_heap #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_HEAP(0)) u_min (
    .clk(clk), .reset(reset), .cmd_valid(m_valid), .cmd_ready(m_ready),
    .cmd_op(m_op), .cmd_data(m_data), .res_valid(m_rv), .res_data(m_rd),
    .err(m_err), .count(m_count), .empty(m_empty), .full(m_full), .busy(m_busy)
  );

  int errors = 0;
  int checks = 0;
  logic          rv_s, err_s;
  logic [DW-1:0] rd_s;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] data;
    logic          rv;
    logic          er;
    logic [DW-1:0] rd;
    int            cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a command, waits for acceptance, captures the pulse cycle, then waits for idle.
  task automatic issue(input bit mn, input logic [1:0] op, input logic [DW-1:0] d);
    int n = 0;
    if (mn) begin m_valid = 1'b1; m_op = op; m_data = d; end
    else begin cmd_valid = 1'b1; cmd_op = op; cmd_data = d; end
    while (!(mn ? m_ready : cmd_ready) && n < 100) begin tick(); n++; end
    if (n >= 100) timeout_fail("ready_wait");
    tick();
    rv_s  = mn ? m_rv  : res_valid;
    err_s = mn ? m_err : err;
    rd_s  = mn ? m_rd  : res_data;
    m_valid   = 1'b0;
    cmd_valid = 1'b0;
    n = 0;
    while ((mn ? m_busy : busy) && n < 100) begin tick(); n++; end
    if (n >= 100) timeout_fail("idle_wait");
  endtask

  vec_t vt[$];
  int   vals[$];
  int   n;

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_op = CLR; cmd_data = '0;
    m_valid = 1'b0; m_op = CLR; m_data = '0;
    #8;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_res_data", res_data, 0);
    #4 reset = 1'b1;

    vt.push_back('{PSH, 8'd5, 1'b0, 1'b0, 8'd0, 1});
    vt.push_back('{PSH, 8'd9, 1'b0, 1'b0, 8'd0, 2});
    vt.push_back('{PSH, 8'd3, 1'b0, 1'b0, 8'd0, 3});
    vt.push_back('{PSH, 8'd9, 1'b0, 1'b0, 8'd0, 4});
    vt.push_back('{PSH, 8'd1, 1'b0, 1'b0, 8'd0, 5});
    vt.push_back('{POP, 8'd0, 1'b1, 1'b0, 8'd9, 4});
    vt.push_back('{POP, 8'd0, 1'b1, 1'b0, 8'd9, 3});
    vt.push_back('{POP, 8'd0, 1'b1, 1'b0, 8'd5, 2});
    vt.push_back('{POP, 8'd0, 1'b1, 1'b0, 8'd3, 1});
    vt.push_back('{POP, 8'd0, 1'b1, 1'b0, 8'd1, 0});
    vt.push_back('{POP, 8'd0, 1'b0, 1'b1, 8'd0, 0});
    vt.push_back('{REP, 8'd7, 1'b0, 1'b1, 8'd0, 0});
    vt.push_back('{PSH, 8'd9, 1'b0, 1'b0, 8'd0, 1});
    vt.push_back('{PSH, 8'd5, 1'b0, 1'b0, 8'd0, 2});
    vt.push_back('{PSH, 8'd3, 1'b0, 1'b0, 8'd0, 3});
    vt.push_back('{REP, 8'd4, 1'b1, 1'b0, 8'd9, 3});
    vt.push_back('{POP, 8'd0, 1'b1, 1'b0, 8'd5, 2});
    vt.push_back('{POP, 8'd0, 1'b1, 1'b0, 8'd4, 1});
    vt.push_back('{POP, 8'd0, 1'b1, 1'b0, 8'd3, 0});
    vt.push_back('{PSH, 8'd4, 1'b0, 1'b0, 8'd0, 1});
    vt.push_back('{REP, 8'd8, 1'b1, 1'b0, 8'd4, 1});
    vt.push_back('{POP, 8'd0, 1'b1, 1'b0, 8'd8, 0});
    vt.push_back('{PSH, 8'd7, 1'b0, 1'b0, 8'd0, 1});
    vt.push_back('{PSH, 8'd2, 1'b0, 1'b0, 8'd0, 2});
    vt.push_back('{CLR, 8'd0, 1'b0, 1'b0, 8'd0, 0});
    vt.push_back('{POP, 8'd0, 1'b0, 1'b1, 8'd0, 0});

    foreach (vt[i]) begin
      issue(1'b0, vt[i].op, vt[i].data);
      chk($sformatf("v%0d_res_valid", i), rv_s, vt[i].rv);
      chk($sformatf("v%0d_err", i), err_s, vt[i].er);
      if (vt[i].rv) chk($sformatf("v%0d_res_data", i), rd_s, vt[i].rd);
      chk($sformatf("v%0d_count", i), count, vt[i].cnt);
      chk($sformatf("v%0d_empty", i), empty, vt[i].cnt == 0);
    end

    // Fill to DEPTH, overflow, then drain in sorted order and underflow.
    for (int i = 0; i < DEPTH; i++) begin
      vals.push_back((i * 37 + 11) % 256);
      issue(1'b0, PSH, DW'(vals[i]));
    end
    chk("fill_count", count, DEPTH);
    chk("fill_full", full, 1);
    issue(1'b0, PSH, 8'd200);
    chk("ovf_err", err_s, 1);
    chk("ovf_res_valid", rv_s, 0);
    chk("ovf_count", count, DEPTH);
    chk("ovf_full", full, 1);
    vals.rsort();
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b0, POP, 8'd0);
      chk($sformatf("drain%0d_res_data", i), rd_s, vals[i]);
    end
    chk("drain_count", count, 0);
    issue(1'b0, POP, 8'd0);
    chk("udf_err", err_s, 1);
    chk("udf_res_valid", rv_s, 0);

    // Min heap ordering.
    issue(1'b1, PSH, 8'd7);
    issue(1'b1, PSH, 8'd2);
    issue(1'b1, PSH, 8'd8);
    issue(1'b1, POP, 8'd0);
    chk("min_res_data", rd_s, 2);
    chk("min_count", m_count, 2);
    issue(1'b1, POP, 8'd0);
    chk("min_res_data2", rd_s, 7);

    // Command held valid across a sift-up must stall and then be taken once.
    issue(1'b0, PSH, 8'd1);
    cmd_valid = 1'b1; cmd_op = PSH; cmd_data = 8'd10;
    tick();
    cmd_data = 8'd20;
    chk("hold_busy", busy, 1);
    chk("hold_ready", cmd_ready, 0);
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (n >= 100) timeout_fail("hold_ready_wait");
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    if (n >= 100) timeout_fail("hold_idle_wait");
    chk("hold_count", count, 3);
    issue(1'b0, POP, 8'd0); chk("hold_pop0", rd_s, 20);
    issue(1'b0, POP, 8'd0); chk("hold_pop1", rd_s, 10);
    issue(1'b0, POP, 8'd0); chk("hold_pop2", rd_s, 1);

    // Reset asserted in the middle of a sift-down.
    for (int i = 1; i <= 5; i++) issue(1'b0, PSH, DW'(i));
    cmd_valid = 1'b1; cmd_op = POP; cmd_data = '0;
    tick();
    cmd_valid = 1'b0;
    chk("mid_busy", busy, 1);
    chk("mid_res_data", res_data, 5);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    #1 reset = 1'b1;
    issue(1'b0, PSH, 8'd6);
    chk("post_rst_push_count", count, 1);
    issue(1'b0, POP, 8'd0);
    chk("post_rst_pop_data", rd_s, 6);
    chk("post_rst_pop_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c3_priority_heap.md
C3_PRIORITY_HEAP -- requirements
Module: c3_priority_heap

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning key width in bits (range 1..32).
REQ-002 SHALL have parameter DEPTH, default 16, meaning maximum number of stored entries (range 2..256).
REQ-003 SHALL have parameter MAX_HEAP, default 1, meaning root ordering: 1 keeps the largest key at the root, 0 keeps the smallest.
REQ-004 SHALL define CW = clog2(DEPTH+1) as the width of the count output.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-008 SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-009 SHALL have port cmd_op, input, 2 bits: 00 CLEAR, 01 PUSH, 10 POP, 11 REPLACE.
REQ-010 SHALL have port cmd_data, input, DATA_W bits: key for PUSH or REPLACE.
REQ-011 SHALL have port res_valid, output, 1 bit: one-cycle pulse, res_data is valid.
REQ-012 SHALL have port res_data, output, DATA_W bits: key removed by POP or REPLACE.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse, the accepted command was illegal.
REQ-014 SHALL have port count, output, CW bits: current number of entries.
REQ-015 SHALL have ports empty and full, outputs, 1 bit each: count==0 and count==DEPTH.
REQ-016 SHALL have port busy, output, 1 bit: a sift is in progress.

Function
REQ-017 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; cmd_ready SHALL be 1 only in state IDLE.
REQ-018 SHALL implement states IDLE, SIFT_UP and SIFT_DOWN; busy SHALL be 1 in any state other than IDLE.
REQ-019 SHALL "win" a comparison under these rules: with MAX_HEAP=1, a wins over b when a>b (unsigned); with MAX_HEAP=0, when a<b; equal keys SHALL never swap.
REQ-020 SHALL handle an accepted PUSH when not full as follows: heap[count] <= cmd_data, count+1, idx <= old count, next state SIFT_UP.
REQ-021 SHALL perform one parent/child comparison per cycle in SIFT_UP, with parent = (idx-1)>>1: if idx>0 and heap[idx] wins over heap[parent], swap them and set idx <= parent; otherwise go to IDLE.
REQ-022 SHALL handle an accepted POP when not empty as follows: res_data <= heap[0], res_valid=1 the next cycle, heap[0] <= heap[count-1], count-1, idx <= 0, next state SIFT_DOWN; if the new count is 0 or 1, go straight to IDLE.
REQ-023 SHALL handle an accepted REPLACE when not empty as follows: res_data <= heap[0], res_valid=1 the next cycle, heap[0] <= cmd_data, count unchanged, next state SIFT_DOWN (IDLE if count==1).
REQ-024 SHALL perform one level per cycle in SIFT_DOWN: select the winner among idx, 2idx+1 and 2idx+2, considering only children with index < count; if the winner is not idx, swap and set idx <= winner; otherwise go to IDLE.
REQ-025 SHALL handle an accepted CLEAR by setting count <= 0 in one cycle and staying in IDLE; array contents are don't-care.
REQ-026 SHALL treat PUSH when full, and POP or REPLACE when empty, as illegal: err=1 the next cycle, no change to state, count or array, and res_valid stays 0.
REQ-027 SHALL produce status and output timing as follows:
- count, empty and full are registered and update on the acceptance edge.
- res_valid and err are never 1 together.
REQ-028 SHALL hold res_data until the next POP or REPLACE.
REQ-029 SHALL keep the latency of a single sift at most floor(log2(DEPTH)) cycles.
REQ-030 SHALL keep the heap property valid for entries 0..count-1 whenever state is IDLE.

Reset
REQ-031 SHALL force, on reset low and asynchronously, the following: state IDLE, count 0, empty 1, full 0, busy 0, cmd_ready 1, res_valid 0, err 0, res_data 0.
REQ-032 SHALL abort any operation in progress when reset asserts mid-sift; after release the block is empty and idle.
REQ-033 SHALL make the first command acceptable on the first rising edge after reset deasserts.

Verification
REQ-034 SHALL cover: max heap, push 5, 9, 3, 9, 1 then five POPs -> res_data 9, 9, 5, 3, 1; count ends at 0.
REQ-035 SHALL cover: MAX_HEAP=0, push 7, 2, 8 then POP -> res_data 2, and count=2.
REQ-036 SHALL cover: DEPTH=16 filled with 16 PUSHes, then a 17th PUSH -> err pulse, count stays 16, full=1; then POP on an empty heap -> err pulse, res_valid=0.
REQ-037 SHALL cover: heap {9, 5, 3}, REPLACE 4 -> res_data 9, count 3, then POPs give 5, 4, 3.
REQ-038 SHALL cover: cmd_valid held high during SIFT_UP after a PUSH -> cmd_ready stays 0 until IDLE, and the command is not lost.
REQ-039 SHALL cover: reset pulsed low during SIFT_DOWN, then PUSH 6 and POP -> res_data 6 and count 0.
